md_sched: RTL

- Sequencer for the E-stage multiply/divide resource of the P7 pipeline.
- Accepts one decoded HI/LO operation per cycle: mult, multu, div, divu, mthi or mtlo.
- Models the fixed multi-cycle latency and owns the architectural HI/LO registers.
- Generates the D-stage stall request for any HI/LO-using instruction that arrives while the unit is occupied, and honours exception flushes from the CP0 path.

---
 rtl/md_sched_pkg.sv | 35 +++
 rtl/md_sched_compute.sv | 69 ++++++
 rtl/md_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// default latencies, FSM state encodings and a small op classifier.
package md_sched_pkg;

  localparam int MD_CNT_W        = 5;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the four ops that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // True for the divide ops, which use the longer latency.
  function automatic logic is_div(input logic [2:0] op);
    return (op == 3'd3) || (op == 3'd4);
  endfunction

endpackage

// File: rtl/md_sched_compute.sv
// md_compute: purely combinational HI/LO result generator for
// mult/multu/div/divu. A zero divisor returns the current HI/LO unchanged.
module md_compute
  import md_sched_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic        div_zero;

  assign sa     = {{32{a[31]}}, a};
  assign sb     = {{32{b[31]}}, b};
  assign prod_s = sa * sb;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps to
  // 0x80000000 instead of relying on overflow behaviour of a signed '/'.
  assign abs_a    = a[31] ? (~a + 32'd1) : a;
  assign abs_b    = b[31] ? (~b + 32'd1) : b;
  assign div_zero = (b == 32'd0);
  assign mag_q    = div_zero ? 32'd0 : (abs_a / abs_b);
  assign mag_r    = div_zero ? 32'd0 : (abs_a % abs_b);
  assign sq       = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
  assign sr       = a[31] ? (~mag_r + 32'd1) : mag_r;
  assign uq       = div_zero ? 32'd0 : (a / b);
  assign ur       = div_zero ? 32'd0 : (a % b);

  // Select the result pair for the op; anything else holds HI/LO.
  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (md_op_e'(op))
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        if (!div_zero) begin
          res_hi = sr;
          res_lo = sq;
        end
      end
      MD_DIVU: begin
        if (!div_zero) begin
          res_hi = ur;
          res_lo = uq;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: E-stage multiply/divide sequencer. Owns HI/LO, models the fixed
// mult/div latency and raises the D-stage stall for HI/LO users while busy.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         pend_hi_q, pend_hi_d;
  logic [31:0]         pend_lo_q, pend_lo_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         res_hi, res_lo;
  logic                acc;

  md_compute u_compute (
    .op     (md_op),
    .a      (rs_val),
    .b      (rt_val),
    .cur_hi (hi_q),
    .cur_lo (lo_q),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign acc       = is_muldiv(md_op) && !flush && (state_q == ST_IDLE);
  assign start     = acc;
  assign busy      = (state_q == ST_BUSY);
  assign stall_req = d_uses_md && (start || busy);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Next-state logic: accept ops in IDLE, count down and commit in BUSY.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          cnt_d     = is_div(md_op) ? DIV_LOAD : MULT_LOAD;
          state_d   = ST_BUSY;
        end else if (!flush && (md_op == MD_MTHI)) begin
          hi_d = rs_val;
        end else if (!flush && (md_op == MD_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_BUSY: begin
        if (cnt_q == MD_CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule
